// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states, PC select codes,
// exception cause codes and exception vectors.
package pipe_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StExc     = 2'd2
    } state_e;

    localparam logic [1:0] PCSEL_SEQ = 2'd0;
    localparam logic [1:0] PCSEL_JMP = 2'd1;
    localparam logic [1:0] PCSEL_BR  = 2'd2;
    localparam logic [1:0] PCSEL_EXC = 2'd3;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_IRQ   = 2'd1;
    localparam logic [1:0] CAUSE_ILLOP = 2'd2;
    localparam logic [1:0] CAUSE_BUS   = 2'd3;

    localparam logic [31:0] VEC_RESET   = 32'h8000_0000;
    localparam logic [31:0] VEC_GENERAL = 32'h8000_0004;
    localparam logic [31:0] VEC_BUS     = 32'h8000_0008;

    // Vector the datapath should load when pc_sel selects the exception entry.
    function automatic logic [31:0] exc_vector(input logic [1:0] cause);
        return (cause == CAUSE_BUS) ? VEC_BUS : VEC_GENERAL;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if;

    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_jump;
    logic       id_illop;
    logic       ex_MemRead;
    logic [4:0] ex_WrReg;
    logic       ex_branch_taken;
    logic       mem_req;
    logic       mem_ack;
    logic       irq;
    logic       kernel;

    logic       pc_en;
    logic [1:0] pc_sel;
    logic [1:0] exc_cause;
    logic       epc_wr;
    logic       ifid_en;
    logic       idex_en;
    logic       exmem_en;
    logic       memwb_en;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic       memwb_flush;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_jump, id_illop,
               ex_MemRead, ex_WrReg, ex_branch_taken, mem_req, mem_ack, irq, kernel,
        input  pc_en, pc_sel, exc_cause, epc_wr, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_jump, id_illop,
               ex_MemRead, ex_WrReg, ex_branch_taken, mem_req, mem_ack, irq, kernel,
        output pc_en, pc_sel, exc_cause, epc_wr, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by the ID instruction.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_use_rs,
    input  logic       i_id_use_rt,
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_wr_reg,
    output logic       o_load_use
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = i_id_use_rs && (i_id_rs == i_ex_wr_reg);
    assign w_rt_hit = i_id_use_rt && (i_id_rt == i_ex_wr_reg);

    // $0 is hardwired, so a load targeting it never produces a value worth waiting for.
    assign o_load_use = i_ex_mem_read && (i_ex_wr_reg != 5'd0) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stalls, flushes and redirects the 5-stage pipeline for load-use,
// branch/jump, data-memory waits (with timeout) and exception entry.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned WAIT_W   = 4,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  bus
);

    state_e              r_state;
    state_e              w_state_d;
    logic [WAIT_W-1:0]   r_cnt;
    logic [WAIT_W-1:0]   w_cnt_d;

    logic                w_load_use;
    logic                w_exc_req;

    logic                w_pc_en;
    logic [1:0]          w_pc_sel;
    logic [1:0]          w_exc_cause;
    logic                w_epc_wr;
    logic [3:0]          w_en;     // {ifid, idex, exmem, memwb}
    logic [3:0]          w_flush;  // {ifid, idex, exmem, memwb}

    hazard_detect u_hazard_detect (
        .i_id_rs       (bus.id_rs),
        .i_id_rt       (bus.id_rt),
        .i_id_use_rs   (bus.id_use_rs),
        .i_id_use_rt   (bus.id_use_rt),
        .i_ex_mem_read (bus.ex_MemRead),
        .i_ex_wr_reg   (bus.ex_WrReg),
        .o_load_use    (w_load_use)
    );

    assign w_exc_req = bus.id_illop || (bus.irq && !bus.kernel);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StRun;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_pc_en     = 1'b1;
        w_pc_sel    = PCSEL_SEQ;
        w_exc_cause = CAUSE_NONE;
        w_epc_wr    = 1'b0;
        w_en        = 4'b1111;
        w_flush     = 4'b0000;

        if (reset) begin
            w_state_d = StRun;
            w_cnt_d   = '0;
            w_pc_en   = 1'b0;
            w_en      = 4'b0000;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (bus.mem_req && !bus.mem_ack) begin
                        w_pc_en   = 1'b0;
                        w_en      = 4'b0001;
                        w_flush   = 4'b0001;
                        w_state_d = StMemWait;
                        w_cnt_d   = WAIT_W'(1);
                    end else if (w_exc_req) begin
                        w_pc_sel    = PCSEL_EXC;
                        w_epc_wr    = 1'b1;
                        w_flush     = 4'b1100;
                        w_exc_cause = bus.id_illop ? CAUSE_ILLOP : CAUSE_IRQ;
                        w_state_d   = StExc;
                    end else if (w_load_use) begin
                        w_pc_en = 1'b0;
                        w_en    = 4'b0111;
                        w_flush = 4'b0100;
                    end else if (bus.ex_branch_taken) begin
                        w_pc_sel = PCSEL_BR;
                        w_flush  = 4'b1100;
                    end else if (bus.id_jump) begin
                        w_pc_sel = PCSEL_JMP;
                        w_flush  = 4'b1000;
                    end
                end

                StMemWait: begin
                    // Redirect inputs are held off until the pipeline is moving again.
                    if (bus.mem_ack) begin
                        w_state_d = StRun;
                        w_cnt_d   = '0;
                    end else if (r_cnt == WAIT_W'(MAX_WAIT)) begin
                        w_pc_sel    = PCSEL_EXC;
                        w_epc_wr    = 1'b1;
                        w_exc_cause = CAUSE_BUS;
                        w_flush     = 4'b1111;
                        w_state_d   = StExc;
                        w_cnt_d     = '0;
                    end else begin
                        w_pc_en = 1'b0;
                        w_en    = 4'b0001;
                        w_flush = 4'b0001;
                        w_cnt_d = r_cnt + WAIT_W'(1);
                    end
                end

                StExc: begin
                    // Entry cycle: new exceptions stay masked until the handler's kernel bit lands.
                    w_state_d = StRun;
                end

                default: begin
                    w_state_d = StRun;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    assign bus.pc_en       = w_pc_en;
    assign bus.pc_sel      = w_pc_sel;
    assign bus.exc_cause   = w_exc_cause;
    assign bus.epc_wr      = w_epc_wr;
    assign bus.ifid_en     = w_en[3];
    assign bus.idex_en     = w_en[2];
    assign bus.exmem_en    = w_en[1];
    assign bus.memwb_en    = w_en[0];
    assign bus.ifid_flush  = w_flush[3];
    assign bus.idex_flush  = w_flush[2];
    assign bus.exmem_flush = w_flush[1];
    assign bus.memwb_flush = w_flush[0];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random stimulus,
// all compared against a behavioural model of the pipeline sequencing rules.
module tb_pipe_hazard_ctrl;

    localparam int unsigned WaitW   = 4;
    localparam int unsigned MaxWait = 15;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       jump;
        logic       illop;
        logic       memread;
        logic [4:0] wr;
        logic       br;
        logic       req;
        logic       ack;
        logic       irq;
        logic       kernel;
    } stim_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    // Model state: number of stalled memory-wait cycles so far (0 = not waiting),
    // and whether the previous cycle was an exception entry.
    int   m_wait = 0;
    bit   m_exc  = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if u_if ();

    pipe_hazard_ctrl #(
        .WAIT_W   (WaitW),
        .MAX_WAIT (MaxWait)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        reset                = s.rst;
        u_if.id_rs           = s.rs;
        u_if.id_rt           = s.rt;
        u_if.id_use_rs       = s.use_rs;
        u_if.id_use_rt       = s.use_rt;
        u_if.id_jump         = s.jump;
        u_if.id_illop        = s.illop;
        u_if.ex_MemRead      = s.memread;
        u_if.ex_WrReg        = s.wr;
        u_if.ex_branch_taken = s.br;
        u_if.mem_req         = s.req;
        u_if.mem_ack         = s.ack;
        u_if.irq             = s.irq;
        u_if.kernel          = s.kernel;
        #2;
    endtask

    // {pc_en, ifid/idex/exmem/memwb en, ifid/idex/exmem/memwb flush, pc_sel, exc_cause, epc_wr}
    function automatic logic [13:0] dut_vec();
        return {u_if.pc_en, u_if.ifid_en, u_if.idex_en, u_if.exmem_en, u_if.memwb_en,
                u_if.ifid_flush, u_if.idex_flush, u_if.exmem_flush, u_if.memwb_flush,
                u_if.pc_sel, u_if.exc_cause, u_if.epc_wr};
    endfunction

    function automatic logic [13:0] model_out(input stim_t s);
        logic       pc_en;
        logic [3:0] en;
        logic [3:0] fl;
        logic [1:0] sel;
        logic [1:0] cause;
        logic       epc;
        logic       lu;
        pc_en = 1'b1; en = 4'hF; fl = 4'h0; sel = 2'd0; cause = 2'd0; epc = 1'b0;
        lu = s.memread && (s.wr != 5'd0)
             && ((s.use_rs && s.rs == s.wr) || (s.use_rt && s.rt == s.wr));
        if (s.rst) return 14'd0;
        if (m_exc) begin
            // exception entry cycle: pipeline runs freely
        end else if (m_wait > 0) begin
            if (s.ack) begin
            end else if (m_wait == int'(MaxWait)) begin
                sel = 2'd3; cause = 2'd3; epc = 1'b1; fl = 4'hF;
            end else begin
                pc_en = 1'b0; en = 4'b0001; fl = 4'b0001;
            end
        end else if (s.req && !s.ack) begin
            pc_en = 1'b0; en = 4'b0001; fl = 4'b0001;
        end else if (s.illop || (s.irq && !s.kernel)) begin
            sel = 2'd3; epc = 1'b1; fl = 4'b1100; cause = s.illop ? 2'd2 : 2'd1;
        end else if (lu) begin
            pc_en = 1'b0; en = 4'b0111; fl = 4'b0100;
        end else if (s.br) begin
            sel = 2'd2; fl = 4'b1100;
        end else if (s.jump) begin
            sel = 2'd1; fl = 4'b1000;
        end
        return {pc_en, en, fl, sel, cause, epc};
    endfunction

    task automatic advance(input stim_t s);
        if (s.rst) begin
            m_wait = 0; m_exc = 1'b0;
        end else if (m_exc) begin
            m_exc = 1'b0;
        end else if (m_wait > 0) begin
            if (s.ack) m_wait = 0;
            else if (m_wait == int'(MaxWait)) begin m_wait = 0; m_exc = 1'b1; end
            else m_wait = m_wait + 1;
        end else if (s.req && !s.ack) begin
            m_wait = 1;
        end else if (s.illop || (s.irq && !s.kernel)) begin
            m_exc = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        stim_t s;
        logic [13:0] got;
        for (int i = 0; i < 2; i++) begin
            s = idle(); s.rst = 1'b1; s.jump = 1'b1; s.req = 1'b1; s.irq = 1'b1;
            apply(s);
            got = dut_vec(); total++;
            if (got !== 14'd0) begin
                bad++; $display("FAIL reset cyc%0d: got=%b exp=%b", i, got, 14'd0);
            end
            advance(s);
        end
    endtask

    task automatic test_load_use();
        stim_t seq [3];
        logic [13:0] got, exp;
        seq[0] = idle(); seq[0].memread = 1'b1; seq[0].wr = 5'd5; seq[0].rs = 5'd5;
        seq[0].use_rs = 1'b1;
        seq[1] = idle(); seq[1].rs = 5'd5; seq[1].use_rs = 1'b1;
        seq[2] = idle(); seq[2].memread = 1'b1; seq[2].wr = 5'd7; seq[2].rt = 5'd7;
        seq[2].use_rt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(seq[i]);
            exp = model_out(seq[i]); got = dut_vec(); total++;
            if (got !== exp) begin
                bad++; $display("FAIL load_use cyc%0d: got=%b exp=%b", i, got, exp);
            end
            advance(seq[i]);
        end
    endtask

    task automatic test_no_stall_r0();
        stim_t s;
        logic [13:0] got;
        s = idle(); s.memread = 1'b1; s.wr = 5'd0; s.rs = 5'd0; s.use_rs = 1'b1;
        s.rt = 5'd0; s.use_rt = 1'b1;
        apply(s);
        got = dut_vec(); total++;
        if (got !== 14'b1_1111_0000_00_00_0) begin
            bad++; $display("FAIL load_use_r0: got=%b exp=%b", got, 14'b1_1111_0000_00_00_0);
        end
        advance(s);
    endtask

    task automatic test_mem_wait();
        stim_t s;
        logic [13:0] got, exp;
        logic ack_pat [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic req_pat [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            s = idle(); s.req = req_pat[i]; s.ack = ack_pat[i]; s.jump = (i == 3);
            apply(s);
            exp = model_out(s); got = dut_vec(); total++;
            if (got !== exp) begin
                bad++; $display("FAIL mem_wait cyc%0d: got=%b exp=%b", i, got, exp);
            end
            advance(s);
        end
    endtask

    task automatic test_timeout();
        stim_t s;
        logic [13:0] got, exp;
        int hit;
        hit = -1;
        s = idle(); s.req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            apply(s);
            exp = model_out(s); got = dut_vec(); total++;
            if (got !== exp) begin
                bad++; $display("FAIL timeout cyc%0d: got=%b exp=%b", i, got, exp);
            end
            if (got[2:1] == 2'd3) hit = i;
            advance(s);
            if (hit >= 0) break;
        end
        total++;
        if (hit != int'(MaxWait)) begin
            bad++; $display("FAIL timeout_cycle: got=%0d exp=%0d", hit, MaxWait);
        end
        for (int i = 0; i < 2; i++) begin
            s = idle(); s.irq = (i == 0);
            apply(s);
            exp = model_out(s); got = dut_vec(); total++;
            if (got !== exp) begin
                bad++; $display("FAIL timeout_exit cyc%0d: got=%b exp=%b", i, got, exp);
            end
            advance(s);
        end
    endtask

    task automatic test_branch_jump();
        stim_t seq [4];
        logic [13:0] got, exp;
        seq[0] = idle(); seq[0].br = 1'b1; seq[0].jump = 1'b1;
        seq[1] = idle(); seq[1].jump = 1'b1;
        seq[2] = idle(); seq[2].br = 1'b1;
        seq[3] = idle(); seq[3].jump = 1'b1; seq[3].memread = 1'b1; seq[3].wr = 5'd9;
        seq[3].rt = 5'd9; seq[3].use_rt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply(seq[i]);
            exp = model_out(seq[i]); got = dut_vec(); total++;
            if (got !== exp) begin
                bad++; $display("FAIL branch_jump cyc%0d: got=%b exp=%b", i, got, exp);
            end
            advance(seq[i]);
        end
    endtask

    task automatic test_irq();
        stim_t seq [6];
        logic [13:0] got, exp;
        seq[0] = idle(); seq[0].irq = 1'b1;
        seq[1] = idle(); seq[1].irq = 1'b1;
        seq[2] = idle(); seq[2].irq = 1'b1; seq[2].kernel = 1'b1;
        seq[3] = idle(); seq[3].irq = 1'b1; seq[3].illop = 1'b1; seq[3].br = 1'b1;
        seq[4] = idle(); seq[4].illop = 1'b1;
        seq[5] = idle(); seq[5].illop = 1'b1; seq[5].kernel = 1'b1;
        for (int i = 0; i < 6; i++) begin
            apply(seq[i]);
            exp = model_out(seq[i]); got = dut_vec(); total++;
            if (got !== exp) begin
                bad++; $display("FAIL irq cyc%0d: got=%b exp=%b", i, got, exp);
            end
            advance(seq[i]);
        end
    endtask

    task automatic test_reset_mid_wait();
        stim_t s;
        logic [13:0] got, exp;
        for (int i = 0; i < 6; i++) begin
            s = idle(); s.req = (i < 4); s.rst = (i == 3); s.jump = (i == 5);
            apply(s);
            exp = model_out(s); got = dut_vec(); total++;
            if (got !== exp) begin
                bad++; $display("FAIL reset_mid_wait cyc%0d: got=%b exp=%b", i, got, exp);
            end
            advance(s);
        end
    endtask

    task automatic test_random();
        stim_t s;
        logic [13:0] got, exp;
        for (int i = 0; i < 400; i++) begin
            s         = idle();
            s.rst     = ($urandom_range(0, 59) == 0);
            s.rs      = 5'($urandom_range(0, 3));
            s.rt      = 5'($urandom_range(0, 3));
            s.wr      = 5'($urandom_range(0, 3));
            s.use_rs  = 1'($urandom_range(0, 1));
            s.use_rt  = 1'($urandom_range(0, 1));
            s.memread = 1'($urandom_range(0, 1));
            s.jump    = ($urandom_range(0, 4) == 0);
            s.br      = ($urandom_range(0, 4) == 0);
            s.illop   = ($urandom_range(0, 19) == 0);
            s.irq     = ($urandom_range(0, 9) == 0);
            s.kernel  = 1'($urandom_range(0, 1));
            s.req     = ($urandom_range(0, 5) == 0) || (m_wait > 0);
            s.ack     = ($urandom_range(0, 3) == 0);
            apply(s);
            exp = model_out(s); got = dut_vec(); total++;
            if (got !== exp) begin
                bad++; $display("FAIL random cyc%0d: got=%b exp=%b", i, got, exp);
            end
            advance(s);
        end
    endtask

    initial begin
        apply('{rst: 1'b1, default: '0});
        @(negedge clk);
        test_reset();
        test_load_use();
        test_no_stall_r0();
        test_mem_wait();
        test_timeout();
        test_branch_jump();
        test_irq();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencer for the 5-stage MIPS pipeline. It drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers and the PC write/select. It resolves load-use hazards, branch and jump redirects, multi-cycle data-memory waits with timeout, and interrupt/illegal-op/bus-error entry. Forwarding stays in the datapath; this block only stalls, flushes and redirects.

Parameters:
WAIT_W, 4, width of the memory-wait counter
MAX_WAIT, 15, MEM_WAIT cycles without mem_ack before bus error (must be ≤ 2^WAIT_W−1)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
id_rs  in  5  ID-stage rs index
id_rt  in  5  ID-stage rt index
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_jump  in  1  jump resolved in ID
id_illop  in  1  ID instruction is illegal
ex_MemRead  in  1  EX instruction is a load
ex_WrReg  in  5  EX destination register
ex_branch_taken  in  1  branch resolved taken in EX
mem_req  in  1  MEM stage issues a data access this cycle
mem_ack  in  1  data memory completes the access
irq  in  1  external interrupt, level
kernel  in  1  PC[31] of the ID instruction; interrupts masked when 1
pc_en  out  1  PC register write enable
pc_sel  out  2  0 = PC+4, 1 = jump target, 2 = branch target, 3 = exception vector
exc_cause  out  2  0 = none, 1 = irq (vector 0x80000004), 2 = illop (0x80000004), 3 = bus error (0x80000008)
epc_wr  out  1  capture EPC (ID-stage PC; MEM-stage PC for bus error)
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  synchronous bubble insert on the next edge

Behaviour:
- State register: RUN, MEM_WAIT, EXC. Wait counter: WAIT_W bits. Outputs are combinational from state and inputs (Mealy). Next-state and counter update on the posedge.
- Reset (async): state=RUN, counter=0. While reset is high, all enables=0, all flushes=0, pc_sel=0, epc_wr=0, exc_cause=0.
- Defaults: all enables=1, flushes=0, pc_sel=0, epc_wr=0, exc_cause=0.
- RUN, evaluated in priority order; the first true condition applies:
  1. mem_req & !mem_ack: pc/ifid/idex/exmem en=0; memwb_flush=1. Go to MEM_WAIT with counter=1.
  2. exception (irq & !kernel, or id_illop): pc_sel=3, epc_wr=1, ifid_flush=1, idex_flush=1, exc_cause set (illop has priority over irq). Go to EXC.
  3. load-use (ex_MemRead & ex_WrReg≠0 & ((id_use_rs & id_rs==ex_WrReg) | (id_use_rt & id_rt==ex_WrReg))): pc_en=0, ifid_en=0, idex_flush=1. Exactly one bubble.
  4. ex_branch_taken: pc_sel=2, ifid_flush=1, idex_flush=1. Overrides id_jump in the same cycle.
  5. id_jump: pc_sel=1, ifid_flush=1.
- Single-cycle access: mem_req & mem_ack in the same cycle produces no stall.
- MEM_WAIT: same outputs as RUN rule 1.
  - mem_ack: release (enables=1, memwb_flush=0) and go to RUN. Branch, jump and exception inputs are ignored in this cycle and re-evaluated in RUN.
  - Otherwise the counter increments. When the counter reaches MAX_WAIT with no ack: exc_cause=3, pc_sel=3, epc_wr=1, flush all four stages. Go to EXC.
- EXC: one cycle, all enables=1, all flushes=0. Return to RUN. irq/illop are not accepted in EXC (this gives one cycle of masking before the handler's kernel bit takes effect).
- ex_WrReg=0 never creates a load-use stall.

Decomposition:
- Shared package pipe_pkg: state encoding, pc_sel codes (PCSEL_SEQ/JMP/BR/EXC), cause codes, exception vectors 0x80000000/0x80000004/0x80000008.
- One sub-module, hazard_detect: the purely combinational load-use comparator. The FSM and counter live in the top.

Test Plan:
- lw $5 in EX (ex_MemRead=1, ex_WrReg=5), ID reads rs=5 → 1 cycle of pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables=1.
- Same as above with ex_WrReg=0 and rs=0 → no stall.
- mem_req=1 with mem_ack after 3 cycles → 3 cycles in MEM_WAIT with memwb_flush=1 and other enables=0; returns to RUN with ack. Repeat with mem_ack arriving in the request cycle → zero stall.
- mem_req held, no ack, MAX_WAIT=15 → at wait cycle 15: exc_cause=3, pc_sel=3, epc_wr=1, all four flushes=1; next cycle state is EXC, then RUN.
- ex_branch_taken & id_jump in the same cycle → pc_sel=2, ifid_flush=1, idex_flush=1.
- irq=1 with kernel=0 → pc_sel=3, exc_cause=1, epc_wr=1. With kernel=1 → no action. Assert reset mid-MEM_WAIT → outputs go to reset values immediately; state=RUN after reset deasserts.
